// File: rtl/regfile_wport_arbiter_if.sv
// Signal bundle between the writeback stage, the long-latency unit, issue logic and the
// register file write port. slave = the arbiter, master = everything that talks to it.
interface regfile_wport_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                      WB_WE;
    logic [ADDR_W-1:0]         WB_A3;
    logic [DATA_W-1:0]         WB_WD;
    // LU handshake: an entry is handed over on any cycle where LU_Valid and LU_Ready are both high
    logic                      LU_Valid;
    logic [ADDR_W-1:0]         LU_A3;
    logic [DATA_W-1:0]         LU_WD;
    logic                      LU_Ready;
    logic                      Issue_Req;
    logic [ADDR_W-1:0]         Issue_A3;
    logic                      Issue_Stall;
    logic [(1<<ADDR_W)-1:0]    Busy;
    logic                      Pipe_Stall;
    logic                      WE3;
    logic [ADDR_W-1:0]         A3;
    logic [DATA_W-1:0]         WD3;

    modport slave (
        input  WB_WE, WB_A3, WB_WD, LU_Valid, LU_A3, LU_WD, Issue_Req, Issue_A3,
        output LU_Ready, Issue_Stall, Busy, Pipe_Stall, WE3, A3, WD3
    );

    modport master (
        output WB_WE, WB_A3, WB_WD, LU_Valid, LU_A3, LU_WD, Issue_Req, Issue_A3,
        input  LU_Ready, Issue_Stall, Busy, Pipe_Stall, WE3, A3, WD3
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Register file write-port arbiter: WB stage has fixed priority, long-latency results wait in
// a skid FIFO, and a busy scoreboard tracks destinations with long-latency writes in flight.
module regfile_wport_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                     CLK_WrArb,
    input  logic                     RST_WrArb,
    regfile_wport_arbiter_if.slave   bus
);
    localparam int NREGS = 1 << ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_LIM);

    logic [ADDR_W-1:0] fifo_a_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_a_d [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_d_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_d_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              pipe_stall_q, pipe_stall_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    logic lu_ready, push, pop, wb_win, fifo_ne, issue_stall, issue_set;

    always_comb begin
        lu_ready    = (count_q < DEPTH_C);
        fifo_ne     = (count_q != '0);
        wb_win      = bus.WB_WE && (bus.WB_A3 != '0);
        // Register-0 results complete the handshake but are dropped here
        push        = bus.LU_Valid && lu_ready && (bus.LU_A3 != '0);
        pop         = !wb_win && fifo_ne;
        issue_stall = bus.Issue_Req && busy_q[bus.Issue_A3] && (bus.Issue_A3 != '0);
        issue_set   = bus.Issue_Req && !issue_stall && (bus.Issue_A3 != '0);
    end

    always_comb begin
        fifo_a_d = fifo_a_q;
        fifo_d_d = fifo_d_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_a_d[wr_ptr_q] = bus.LU_A3;
            fifo_d_d[wr_ptr_q] = bus.LU_WD;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        we3_d = wb_win || pop;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (wb_win) begin
            a3_d  = bus.WB_A3;
            wd3_d = bus.WB_WD;
        end else if (pop) begin
            a3_d  = fifo_a_q[rd_ptr_q];
            wd3_d = fifo_d_q[rd_ptr_q];
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (wb_win && (starve_q < STARVE_C)) begin
            starve_d = starve_q + SC_W'(1);
        end
        pipe_stall_d = (starve_d >= STARVE_C);
    end

    // Clear before set so an issue to the register being retired keeps it busy
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[fifo_a_q[rd_ptr_q]] = 1'b0;
        end
        if (issue_set) begin
            busy_d[bus.Issue_A3] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK_WrArb) begin
        if (RST_WrArb) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            pipe_stall_q <= 1'b0;
            busy_q       <= '0;
            we3_q        <= 1'b0;
            a3_q         <= '0;
            wd3_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            pipe_stall_q <= pipe_stall_d;
            busy_q       <= busy_d;
            we3_q        <= we3_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
        end
    end

    always_ff @(posedge CLK_WrArb) begin
        fifo_a_q <= fifo_a_d;
        fifo_d_q <= fifo_d_d;
    end

    always_comb begin
        bus.LU_Ready    = lu_ready;
        bus.Issue_Stall = issue_stall;
        bus.Busy        = busy_q;
        bus.Pipe_Stall  = pipe_stall_q;
        bus.WE3         = we3_q;
        bus.A3          = a3_q;
        bus.WD3         = wd3_q;
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: inputs change on negedge, outputs are checked
// around the negedge against hand-computed values.
module tb_regfile_wport_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_wport_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wport_arbiter #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_LIM(4)
    ) dut (
        .CLK_WrArb(clk),
        .RST_WrArb(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.WB_WE     = 1'b0;
        bus.WB_A3     = '0;
        bus.WB_WD     = '0;
        bus.LU_Valid  = 1'b0;
        bus.LU_A3     = '0;
        bus.LU_WD     = '0;
        bus.Issue_Req = 1'b0;
        bus.Issue_A3  = '0;
    endtask

    task automatic lu_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.LU_Valid = v;
        bus.LU_A3    = a;
        bus.LU_WD    = d;
    endtask

    task automatic wb_drive(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.WB_WE = we;
        bus.WB_A3 = a;
        bus.WB_WD = d;
    endtask

    task automatic check_wport(input string tag, input logic we, input logic [4:0] a,
                               input logic [31:0] d);
        check({tag, "_we3"}, 64'(bus.WE3), 64'(we));
        check({tag, "_a3"},  64'(bus.A3),  64'(a));
        check({tag, "_wd3"}, 64'(bus.WD3), 64'(d));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Reset then idle
        repeat (3) tick();
        check_wport("rst", 1'b0, 5'd0, 32'h0);
        check("rst_busy", 64'(bus.Busy), 64'h0);
        check("rst_ready", 64'(bus.LU_Ready), 64'h1);
        check("rst_pstall", 64'(bus.Pipe_Stall), 64'h0);

        // Single WB write, visible one cycle only
        wb_drive(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        check_wport("wb", 1'b1, 5'd5, 32'hDEAD_BEEF);
        wb_drive(1'b0, 5'd0, 32'h0);
        tick();
        check_wport("wb_after", 1'b0, 5'd5, 32'hDEAD_BEEF);

        // Issue to reg 9, restall, then LU completion
        bus.Issue_Req = 1'b1;
        bus.Issue_A3  = 5'd9;
        #1 check("iss_nostall", 64'(bus.Issue_Stall), 64'h0);
        tick();
        check("iss_busy", 64'(bus.Busy), 64'h0000_0200);
        #1 check("iss_stall", 64'(bus.Issue_Stall), 64'h1);
        tick();
        bus.Issue_Req = 1'b0;
        lu_drive(1'b1, 5'd9, 32'h1234);
        #1 check("lu_ready", 64'(bus.LU_Ready), 64'h1);
        tick();
        lu_drive(1'b0, 5'd0, 32'h0);
        check("lu_lat1_we3", 64'(bus.WE3), 64'h0);
        check("lu_lat1_busy", 64'(bus.Busy), 64'h0000_0200);
        tick();
        check_wport("lu_pop", 1'b1, 5'd9, 32'h1234);
        check("lu_pop_busy", 64'(bus.Busy), 64'h0);
        tick();
        check("lu_idle_we3", 64'(bus.WE3), 64'h0);

        // WB held while LU fills the FIFO; starvation then drain
        wb_drive(1'b1, 5'd3, 32'h33);
        lu_drive(1'b1, 5'd7, 32'h77);
        tick();
        lu_drive(1'b1, 5'd8, 32'h88);
        #1 check("st_ready1", 64'(bus.LU_Ready), 64'h1);
        tick();
        lu_drive(1'b1, 5'd10, 32'hAA);
        #1 check("st_ready_full", 64'(bus.LU_Ready), 64'h0);
        tick();
        lu_drive(1'b0, 5'd0, 32'h0);
        check_wport("st_wb", 1'b1, 5'd3, 32'h33);
        check("st_pstall_e3", 64'(bus.Pipe_Stall), 64'h0);
        tick();
        check("st_pstall_e4", 64'(bus.Pipe_Stall), 64'h0);
        tick();
        check("st_pstall_e5", 64'(bus.Pipe_Stall), 64'h1);
        tick();
        check("st_pstall_hold", 64'(bus.Pipe_Stall), 64'h1);
        check_wport("st_wb_wins", 1'b1, 5'd3, 32'h33);
        wb_drive(1'b0, 5'd0, 32'h0);
        tick();
        check_wport("st_pop7", 1'b1, 5'd7, 32'h77);
        check("st_pstall_clr", 64'(bus.Pipe_Stall), 64'h0);
        check("st_ready_drain", 64'(bus.LU_Ready), 64'h1);
        tick();
        check_wport("st_pop8", 1'b1, 5'd8, 32'h88);
        tick();
        check("st_empty_we3", 64'(bus.WE3), 64'h0);

        // WB to reg 0 counts as idle; LU push to reg 0 is swallowed
        wb_drive(1'b1, 5'd0, 32'h5555);
        lu_drive(1'b1, 5'd4, 32'h44);
        tick();
        lu_drive(1'b0, 5'd0, 32'h0);
        check("r0_push_we3", 64'(bus.WE3), 64'h0);
        tick();
        check_wport("r0_pop4", 1'b1, 5'd4, 32'h44);
        wb_drive(1'b0, 5'd0, 32'h0);
        lu_drive(1'b1, 5'd0, 32'h99);
        bus.Issue_Req = 1'b1;
        bus.Issue_A3  = 5'd0;
        #1 check("r0_lu_ready", 64'(bus.LU_Ready), 64'h1);
        check("r0_iss_stall", 64'(bus.Issue_Stall), 64'h0);
        tick();
        idle_inputs();
        tick();
        check("r0_no_write", 64'(bus.WE3), 64'h0);
        check("r0_busy", 64'(bus.Busy), 64'h0);

        // Reset with two queued entries and regs 7/8 busy
        bus.Issue_Req = 1'b1;
        bus.Issue_A3  = 5'd7;
        tick();
        bus.Issue_A3  = 5'd8;
        tick();
        bus.Issue_Req = 1'b0;
        check("pre_rst_busy", 64'(bus.Busy), 64'h0000_0180);
        wb_drive(1'b1, 5'd3, 32'h3);
        lu_drive(1'b1, 5'd7, 32'h70);
        tick();
        lu_drive(1'b1, 5'd8, 32'h80);
        tick();
        lu_drive(1'b0, 5'd0, 32'h0);
        #1 check("pre_rst_full", 64'(bus.LU_Ready), 64'h0);
        check("pre_rst_busy2", 64'(bus.Busy), 64'h0000_0180);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_drive(1'b0, 5'd0, 32'h0);
        check("mid_rst_we3", 64'(bus.WE3), 64'h0);
        check("mid_rst_busy", 64'(bus.Busy), 64'h0);
        check("mid_rst_ready", 64'(bus.LU_Ready), 64'h1);
        check("mid_rst_pstall", 64'(bus.Pipe_Stall), 64'h0);
        tick();
        check("post_rst_we3_a", 64'(bus.WE3), 64'h0);
        tick();
        check("post_rst_we3_b", 64'(bus.WE3), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the 32x32 register file.
- Shares that port between the pipeline writeback stage and a long-latency unit (multiply/divide, load return) through a small skid FIFO.
- Keeps a busy scoreboard of destinations with long-latency writes outstanding, so issue logic can stall on RAW/WAW.
- Sits between WB stage / long-latency unit and the register file; runs on posedge so its registered outputs are stable at the register file's negedge write.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (32 registers)
FIFO_DEPTH, 2, long-latency result skid FIFO entries (power of 2, >=2)
STARVE_LIM, 4, consecutive lost arbitrations before stall request

Ports:
CLK_WrArb  in  1  clock, posedge
RST_WrArb  in  1  reset, synchronous, active-high
WB_WE  in  1  writeback write request (always accepted)
WB_A3  in  ADDR_W  writeback destination
WB_WD  in  DATA_W  writeback data
LU_Valid  in  1  long-latency result valid
LU_A3  in  ADDR_W  long-latency destination
LU_WD  in  DATA_W  long-latency data
LU_Ready  out  1  FIFO can accept (valid&ready = push)
Issue_Req  in  1  long-latency op issuing this cycle
Issue_A3  in  ADDR_W  destination of issuing op
Issue_Stall  out  1  Issue_Req targets a busy register
Busy  out  32  scoreboard, bit n = write to reg n pending
Pipe_Stall  out  1  request hazard unit to bubble WB next cycle
WE3  out  1  register file write enable
A3  out  ADDR_W  register file write address
WD3  out  DATA_W  register file write data

Behaviour:
- Reset (sync, RST_WrArb=1 at posedge):
  - WE3=0, A3=0, WD3=0, Busy=0, Pipe_Stall=0.
  - FIFO emptied, starvation counter=0.
  - LU_Ready=1 from first cycle after reset.
  - Reset mid-operation discards all queued FIFO entries and busy bits; no write issues that cycle.
- Write port outputs are registered: a winner at edge N appears on WE3/A3/WD3 for cycle N+1.
- Arbitration each posedge, fixed priority:
  1. WB_WE=1 and WB_A3!=0 -> WB wins.
  2. Else FIFO non-empty -> pop head, head wins.
  3. Else WE3=0 (A3/WD3 hold previous values).
- Writes to register 0 are never issued:
  - WB_WE with WB_A3=0 is treated as idle, so a FIFO head may win that cycle.
  - LU push with LU_A3=0 is accepted (handshake completes) but discarded, not enqueued.
- FIFO:
  - LU_Ready = (count < FIFO_DEPTH), combinational from count.
  - Push and pop in the same cycle allowed; count unchanged. When full, a same-cycle pop does not raise LU_Ready.
  - Minimum LU latency: push at edge N, earliest pop at N+1, on WE3 during cycle N+2.
  - Pointers wrap modulo FIFO_DEPTH.
- Starvation:
  - Counter increments each cycle FIFO is non-empty and WB wins; resets to 0 on any pop or when FIFO is empty.
  - Pipe_Stall (registered) = 1 while counter >= STARVE_LIM.
  - The hazard unit inserts a bubble in response, so the head wins next cycle.
  - If WB_WE still arrives, WB wins anyway (no data loss); Pipe_Stall stays asserted.
- Scoreboard:
  - Issue_Stall = Issue_Req & Busy[Issue_A3] & (Issue_A3!=0), combinational.
  - At edge: Issue_Req & !Issue_Stall & Issue_A3!=0 sets Busy[Issue_A3].
  - A FIFO pop winning arbitration clears Busy[head A3] in the same edge it loads WE3.
  - Same register set and cleared in one edge: set wins.
  - A WB write to a busy register leaves Busy unchanged.
  - Busy[0] is always 0.

Test Plan:
- Reset then idle 3 cycles -> WE3=0, Busy=0, LU_Ready=1, Pipe_Stall=0.
- WB_WE=1, WB_A3=5, WB_WD=0xDEADBEEF at edge N -> WE3=1, A3=5, WD3=0xDEADBEEF during cycle N+1 only.
- Issue_Req A3=9; later LU_Valid A3=9, WD=0x1234 with WB idle:
  - Busy[9]=1 after issue; a second Issue_Req to 9 gives Issue_Stall=1.
  - Write appears 2 cycles after push; Busy[9]=0 the same cycle WE3=1.
- WB_WE held high (A3=3) while 3 LU pushes (A3=7,8,10):
  - Third push sees LU_Ready=0.
  - Pipe_Stall rises after 4 lost cycles; on WB_WE drop, regs 7 then 8 are written on consecutive cycles.
- WB_WE with WB_A3=0 while FIFO holds A3=4 -> WE3=1 with A3=4 (reg 0 never written).
- RST_WrArb pulsed with 2 FIFO entries and Busy=0x0000_0180 -> next cycle WE3=0, Busy=0, LU_Ready=1, no queued writes emerge.
